// File: rtl/net_delay_monitor_pkg.sv
// Shared types and constants for the net delay monitor.
package net_delay_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    HOLD    = 2'd2
  } state_e;

  // Synchronizer depth on the capture path; also the delay compensation amount.
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/net_delay_monitor_edge_rise_detect.sv
// Rising-edge detector: registered previous value, combinational rise pulse.
module edge_rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= d_i;
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/net_delay_monitor.sv
// Measures launch-to-capture rise delay in cycles, reports over valid/ready.
// Optional NET_DELAY_MON_SYNC_EN: synchronize capture_i and compensate the delay.
module net_delay_monitor
  import net_delay_monitor_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             launch_i,
  input  logic             capture_i,
  output logic             busy_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [CNT_W-1:0] res_delay_o,
  output logic             res_timeout_o,
  output logic             res_overrun_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic             cap_src;
  logic             l_rise, c_rise;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic             to_q, to_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] meas_inc, meas_rep;

`ifdef NET_DELAY_MON_SYNC_EN
  localparam logic [CNT_W-1:0] SYNC_C = CNT_W'(SYNC_STAGES);
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], capture_i};
  end

  assign cap_src  = sync_q[SYNC_STAGES-1];
  // Synchronizer latency is removed from the report, floored at zero.
  assign meas_rep = (meas_inc > SYNC_C) ? (meas_inc - SYNC_C) : '0;
`else
  assign cap_src  = capture_i;
  assign meas_rep = meas_inc;
`endif

  edge_rise_detect u_launch_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (launch_i),
    .rise_o (l_rise)
  );

  edge_rise_detect u_capture_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (cap_src),
    .rise_o (c_rise)
  );

  assign meas_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      delay_q <= '0;
      to_q    <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      to_q    <= to_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    delay_d = delay_q;
    to_d    = to_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (l_rise && c_rise) begin
          state_d = HOLD;
          delay_d = '0;
          to_d    = 1'b0;
        end else if (l_rise) begin
          state_d = MEASURE;
          cnt_d   = '0;
        end
      end
      MEASURE: begin
        // Capture takes priority over a coincident timeout.
        if (c_rise) begin
          state_d = HOLD;
          delay_d = meas_rep;
          to_d    = 1'b0;
        end else if (meas_inc == TIMEOUT_C) begin
          state_d = HOLD;
          delay_d = TIMEOUT_C;
          to_d    = 1'b1;
        end else begin
          cnt_d   = meas_inc;
        end
      end
      HOLD: begin
        if (res_ready_i) begin
          ovr_d = 1'b0;
          if (l_rise) begin
            state_d = MEASURE;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (l_rise) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d  = (state_d == MEASURE);
    valid_d = (state_d == HOLD);
  end

  assign busy_o        = busy_q;
  assign res_valid_o   = valid_q;
  assign res_delay_o   = delay_q;
  assign res_timeout_o = to_q;
  assign res_overrun_o = ovr_q;

endmodule

// File: tb/tb_net_delay_monitor.sv
// Randomized + directed bench for net_delay_monitor against a timestamp-based model.
module tb_net_delay_monitor;

  localparam int CNT_W = 16;
  localparam int TO    = 20;
`ifdef NET_DELAY_MON_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             launch = 1'b0, capture = 1'b0, ready = 1'b0;
  logic             busy, valid, timeout, overrun;
  logic [CNT_W-1:0] delay;

  net_delay_monitor #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .launch_i      (launch),
    .capture_i     (capture),
    .busy_o        (busy),
    .res_valid_o   (valid),
    .res_ready_i   (ready),
    .res_delay_o   (delay),
    .res_timeout_o (timeout),
    .res_overrun_o (overrun)
  );

  always #5 clk = ~clk;

  int vecs = 0, miss = 0;

  // Model: measurement tracked as a start timestamp, delay = elapsed edges.
  int now, start, last_delay, valid_cycles;
  bit m_meas, m_valid, m_to, m_ovr, lprev, cprev, h1, h2, last_to, busy_seen;
  int m_delay;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    now = 0; start = 0; m_meas = 0; m_valid = 0; m_to = 0; m_ovr = 0;
    m_delay = 0; lprev = 0; cprev = 0; h1 = 0; h2 = 0;
  endtask

  task automatic finish_meas(int d, bit t);
    m_meas = 0; m_valid = 1; m_delay = d; m_to = t;
  endtask

  task automatic model_edge();
    bit ceff, lr, cr;
    int el;
    now++;
    ceff = SYNC ? h2 : capture;
    h2 = h1; h1 = capture;
    lr = launch && !lprev;
    cr = ceff && !cprev;
    lprev = launch; cprev = ceff;
    if (m_valid) begin
      if (ready) begin
        m_valid = 0; m_ovr = 0;
        if (lr) begin m_meas = 1; start = now; end
      end else if (lr) m_ovr = 1;
    end else if (m_meas) begin
      el = now - start;
      if (cr) finish_meas(SYNC ? ((el > 2) ? el - 2 : 0) : el, 0);
      else if (el == TO) finish_meas(TO, 1);
    end else begin
      if (lr && cr) finish_meas(0, 0);
      else if (lr) begin m_meas = 1; start = now; end
    end
  endtask

  task automatic tick(bit l, bit c, bit r);
    launch = l; capture = c; ready = r;
    @(posedge clk);
    model_edge();
    #1;
    check("busy", busy, m_meas);
    check("valid", valid, m_valid);
    check("overrun", overrun, m_ovr);
    if (m_valid) begin
      check("delay", delay, m_delay);
      check("timeout", timeout, m_to);
    end
    if (valid) begin
      last_delay = delay; last_to = timeout; valid_cycles++;
    end
    busy_seen |= busy;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(0, 0, 1);
  endtask

  task automatic do_reset(bit l);
    launch = l; capture = 0; ready = 0;
    rst_n = 0;
    model_reset();
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_delay", delay, 0);
    check("rst_timeout", timeout, 0);
    check("rst_overrun", overrun, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset(0);
    idle(4);

    // Launch rise, capture rise 10 cycles later, ready high.
    valid_cycles = 0; last_delay = -1;
    tick(1, 0, 1);
    for (int i = 0; i < 9; i++) tick(1, 0, 1);
    tick(1, 1, 1);
    for (int i = 0; i < 5; i++) tick(0, 0, 1);
    check("t10_delay", last_delay, 10);
    check("t10_timeout", last_to, 0);
    check("t10_vcycles", valid_cycles, 1);

    // Same-cycle launch and capture.
    busy_seen = 0; last_delay = -1;
    tick(1, 1, 1);
    for (int i = 0; i < 4; i++) tick(0, 0, 1);
    check("same_delay", last_delay, 0);
    if (!SYNC) check("same_nobusy", busy_seen, 0);

    // Timeout.
    last_delay = -1; last_to = 0;
    tick(1, 0, 0);
    for (int i = 0; i < TO + 3; i++) tick(0, 0, 0);
    check("to_delay", last_delay, TO);
    check("to_flag", last_to, 1);
    tick(0, 0, 1);

    // Overrun while held, then release to IDLE.
    idle(2);
    tick(1, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0);
    tick(0, 1, 0);
    for (int i = 0; i < 3; i++) tick(0, 1, 0);
    tick(1, 1, 0); tick(0, 1, 0); tick(1, 1, 0); tick(0, 0, 0);
    check("ovr_set", overrun, 1);
    check("ovr_delay", delay, 5);
    tick(0, 0, 1);
    check("ovr_clr", overrun, 0);
    check("ovr_idle_busy", busy, 0);
    check("ovr_idle_valid", valid, 0);

    // Handshake coincides with new launch rise.
    tick(1, 0, 0);
    for (int i = 0; i < 2; i++) tick(0, 0, 0);
    tick(0, 1, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0);
    tick(1, 0, 1);
    check("b2b_busy", busy, 1);
    last_delay = -1;
    for (int i = 0; i < 6; i++) tick(1, 0, 0);
    tick(1, 1, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0);
    check("b2b_delay", last_delay, 7);
    tick(0, 0, 1);

    // Reset mid-measure: nothing stale afterwards.
    tick(1, 0, 1); tick(1, 0, 1); tick(1, 0, 1);
    do_reset(0);
    valid_cycles = 0;
    for (int i = 0; i < TO + 5; i++) tick(0, 0, 1);
    check("rst_nostale", valid_cycles, 0);

    // Launch held high through reset counts as a rise.
    tick(1, 0, 1); tick(1, 0, 1);
    do_reset(1);
    tick(1, 0, 1);
    check("rst_launch_rise", busy, 1);
    idle(TO + 3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 5) == 0) ? ~launch : launch,
           ($urandom_range(0, 6) == 0) ? ~capture : capture,
           $urandom_range(0, 2) != 0);
      if ($urandom_range(0, 999) == 0) do_reset($urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/net_delay_monitor.md
# net_delay_monitor

Receive-side observer for a delayed net: sits at the far end of a continuously-assigned, delayed wire and measures, in clock cycles, how long a rising transition takes to travel from the launch side to the capture side. Each measurement is reported as one result over a valid/ready handshake. A timeout state machine guards against transitions that never arrive. Used in net-delay conformance benches and as a synthesizable latency probe.

## Interface
- CNT_W, 16, width of delay counter and result
- TIMEOUT, 1000, cycles to wait for capture before giving up; must be ≥1 and < 2**CNT_W
- clk  input  1  single clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- launch_i  input  1  source-side net (pre-delay); rising edge starts a measurement
- capture_i  input  1  far-end net (post-delay); rising edge ends a measurement
- busy_o  output  1  high in MEASURE
- res_valid_o  output  1  result available
- res_ready_i  input  1  consumer accepts result
- res_delay_o  output  CNT_W  measured delay in cycles
- res_timeout_o  output  1  result is a timeout, not a measurement
- res_overrun_o  output  1  at least one launch edge was dropped while the result was held

## Operation
- Edge detection: the previous values of launch_i and capture_i are registered (reset 0). A rise is current=1 while previous=0.
- States: IDLE, MEASURE, HOLD.
- IDLE:
  - launch rise without capture rise → MEASURE, counter cleared to 0.
  - Launch and capture rise in the same cycle → HOLD, delay=0, timeout=0.
  - A capture rise alone is ignored.
- MEASURE:
  - Counter increments once per cycle.
  - Capture rise → HOLD, delay = counter+1, which equals the number of edges between the launch-detect edge and the capture-detect edge.
  - Counter+1 == TIMEOUT with no capture rise → HOLD, delay=TIMEOUT, timeout=1.
  - Further launch rises are ignored.
- HOLD:
  - res_valid_o=1 and all result fields are stable.
  - A launch rise sets the overrun flag, which is sticky until the handshake.
  - On valid&&ready: overrun clears. Next state is MEASURE (counter 0) if a launch rise occurs in that same cycle, else IDLE.
- Capture and timeout in the same MEASURE cycle: capture wins, timeout=0.

## Timing
- Reset values: busy_o=0, res_valid_o=0, res_delay_o=0, res_timeout_o=0, res_overrun_o=0, state IDLE, edge history 0.
- All outputs are registered. res_valid_o rises on the edge after the ending event is detected.
- Handshake: valid holds until ready is sampled high. Ready while valid is low has no effect. Back-to-back measurements run with zero idle cycles.
- Reset mid-MEASURE or mid-HOLD: the measurement is lost, no result is produced, and edge history clears. A launch_i held high through reset therefore counts as a rise on the first cycle after reset.
- Arithmetic: counter is CNT_W bits. Counter+1 never wraps because TIMEOUT < 2**CNT_W.

## Configuration
- NET_DELAY_MON_SYNC_EN defined:
  - capture_i passes through a 2-flop synchronizer (reset 0) before edge detection.
  - Reported delay is compensated by subtracting 2, saturating at 0.
  - The timeout threshold is unchanged.
- Undefined: capture_i feeds edge detection directly with no compensation.

## Structure
- Package net_delay_monitor_pkg holds:
  - the state enum (IDLE, MEASURE, HOLD);
  - the SYNC_STAGES=2 constant used for compensation.
- Sub-module edge_rise_detect: registered previous value plus rise pulse, asynchronous active-low reset. It is instantiated once for launch and once for capture.

## Test plan
- Launch rise at cycle 5, capture rise at cycle 15, ready held high → one result with delay=10, timeout=0, valid for 1 cycle.
- Launch and capture rise in the same cycle → delay=0 reported without entering MEASURE.
- Launch rise, no capture, TIMEOUT=20 → result with delay=20, timeout=1 exactly 20 cycles after launch detect.
- Result held with ready low, two launch rises during HOLD → overrun=1 and delay unchanged. After ready, overrun=0 and state is IDLE.
- Ready asserted in the same cycle as a new launch rise → next result measured from that launch, e.g. capture 7 cycles later gives delay=7.
- rst_n pulsed low mid-MEASURE → all outputs 0 immediately, no stale result afterward. With NET_DELAY_MON_SYNC_EN, the 10-cycle case again reports 10.
